// File: rtl/button_event_ctrl_if.sv
// button_event_ctrl_if: event-queue handshake between the debounce controller and its consumer
interface button_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_press;
    logic [3:0] evt_idx;
    modport master (output evt_valid, evt_press, evt_idx, input evt_ready);
    modport slave (input evt_valid, evt_press, evt_idx, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: shared-tick multi-button debouncer feeding a press/release event FIFO
module button_event_ctrl #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   btn_in,
    output logic [N_BTN-1:0]   btn_state,
    output logic               overflow,
    input  logic               clr_overflow,
    button_event_ctrl_if.master evt
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_BTN-1:0] meta, sync, pend, ptype, clr;
    logic [TW-1:0]    tcnt;
    logic [SW-1:0]    scnt [N_BTN];
    logic [4:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    rd, wr, rd_nx;
    logic [AW:0]      cnt, cnt_nx;
    logic [3:0]       sel;
    logic [4:0]       din, head_nx;
    logic             tick, has, psel, pop, push_ok, drop;

    assign tick = tcnt == TW'(TICK_DIV - 1);

    // descending scan so the lowest pending index is the one left selected
    always_comb begin
        has  = 1'b0;
        sel  = '0;
        psel = 1'b0;
        clr  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                has  = 1'b1;
                sel  = 4'(i);
                psel = ptype[i];
                clr  = '0;
                clr[i] = 1'b1;
            end
        end
    end

    assign din     = {psel, sel};
    assign pop     = evt.evt_valid & evt.evt_ready;
    assign push_ok = has & ((cnt < (AW+1)'(FIFO_DEPTH)) | pop);
    assign drop    = has & ~push_ok;
    assign cnt_nx  = cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    assign rd_nx   = rd + AW'(pop);
    // the new head is the entry being written when the queue was otherwise empty
    assign head_nx = (push_ok && wr == rd_nx) ? din : mem[rd_nx];

    always_ff @(posedge clk)
        if (push_ok) mem[wr] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta          <= '0;
            sync          <= '0;
            tcnt          <= '0;
            pend          <= '0;
            ptype         <= '0;
            btn_state     <= '0;
            overflow      <= 1'b0;
            rd            <= '0;
            wr            <= '0;
            cnt           <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_press <= 1'b0;
            evt.evt_idx   <= '0;
            for (int i = 0; i < N_BTN; i++) scnt[i] <= '0;
        end else begin
            meta <= btn_in;
            sync <= meta;
            tcnt <= tick ? '0 : tcnt + 1'b1;
            pend <= pend & ~clr;
            for (int i = 0; i < N_BTN; i++) begin
                if (tick) begin
                    if (sync[i] == btn_state[i]) scnt[i] <= '0;
                    else if (scnt[i] == SW'(STABLE_TICKS - 1)) begin
                        btn_state[i] <= sync[i];
                        scnt[i]      <= '0;
                        pend[i]      <= 1'b1;
                        ptype[i]     <= sync[i];
                    end else scnt[i] <= scnt[i] + 1'b1;
                end
            end
            if (push_ok) wr <= wr + 1'b1;
            rd            <= rd_nx;
            cnt           <= cnt_nx;
            overflow      <= drop | (overflow & ~clr_overflow);
            evt.evt_valid <= cnt_nx != '0;
            {evt.evt_press, evt.evt_idx} <= (cnt_nx != '0) ? head_nx : 5'd0;
        end
    end
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed stimulus with a queue scoreboard and a decoupled event monitor
module tb_button_event_ctrl;
    logic       clk = 1'b0;
    logic       rst, clr_overflow;
    logic [3:0] btn_in, btn_state;
    logic       overflow;
    logic [4:0] sb [$];
    logic [4:0] exp_e;
    int         errors = 0, checks = 0, e = 0;

    button_event_ctrl_if evt();

    button_event_ctrl #(.N_BTN(4), .TICK_DIV(8), .STABLE_TICKS(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_state(btn_state),
        .overflow(overflow), .clr_overflow(clr_overflow), .evt(evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic to_edge(input int k);
        while (e < k) cyc();
    endtask

    task automatic expect_evt(input logic press, input logic [3:0] idx);
        sb.push_back({press, idx});
    endtask

    // events are checked in arrival order whenever the consumer accepts one
    always @(negedge clk) begin
        if (!rst && evt.evt_valid === 1'b1 && evt.evt_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got press=%0d idx=%0d expected none", evt.evt_press, evt.evt_idx);
            end else begin
                exp_e = sb.pop_front();
                chk("event", 32'({evt.evt_press, evt.evt_idx}), 32'(exp_e));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_btn_state"}, 32'(btn_state), 32'd0);
        chk({tag, "_valid"}, 32'(evt.evt_valid), 32'd0);
        chk({tag, "_press"}, 32'(evt.evt_press), 32'd0);
        chk({tag, "_idx"}, 32'(evt.evt_idx), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        btn_in = 4'b0000;
        clr_overflow = 1'b0;
        evt.evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        // clean press and release of button 0
        rst = 1'b0;
        e = 0;
        btn_in = 4'b0001;
        expect_evt(1'b1, 4'd0);
        to_edge(23); chk("press_before", 32'(btn_state), 32'h0);
        to_edge(24); chk("press_at", 32'(btn_state), 32'h1);
        to_edge(40);
        btn_in = 4'b0000;
        expect_evt(1'b0, 4'd0);
        to_edge(63); chk("release_before", 32'(btn_state), 32'h1);
        to_edge(64); chk("release_at", 32'(btn_state), 32'h0);
        to_edge(70); chk("clean_drained", 32'(sb.size()), 32'd0);
        // button 1 bounces on alternate ticks
        for (int j = 0; j < 10; j++) begin
            to_edge(72 + 8 * j);
            btn_in[1] = ~j[0];
        end
        to_edge(152); chk("bounce_state", 32'(btn_state), 32'h0);
        btn_in[1] = 1'b1;
        expect_evt(1'b1, 4'd1);
        to_edge(175); chk("hold_before", 32'(btn_state), 32'h0);
        to_edge(176); chk("hold_at", 32'(btn_state), 32'h2);
        btn_in[1] = 1'b0;
        expect_evt(1'b0, 4'd1);
        to_edge(208); chk("bounce_drained", 32'(evt.evt_valid), 32'd0);
        // all four change together while the consumer stalls
        evt.evt_ready = 1'b0;
        btn_in = 4'b1111;
        for (int i = 0; i < 4; i++) expect_evt(1'b1, 4'(i));
        to_edge(232); chk("simul_valid_before", 32'(evt.evt_valid), 32'd0);
        to_edge(233); chk("simul_valid_after", 32'(evt.evt_valid), 32'd1);
        to_edge(237);
        chk("simul_head", 32'({evt.evt_press, evt.evt_idx}), 32'h10);
        chk("simul_no_overflow", 32'(overflow), 32'd0);
        // releases find the queue full and are dropped
        to_edge(240);
        btn_in = 4'b0000;
        to_edge(264); chk("ovf_before", 32'(overflow), 32'd0);
        to_edge(265); chk("ovf_set", 32'(overflow), 32'd1);
        to_edge(270); chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        to_edge(271); chk("ovf_cleared", 32'(overflow), 32'd0);
        clr_overflow = 1'b0;
        to_edge(272);
        evt.evt_ready = 1'b1;
        to_edge(280);
        chk("ovf_drained_valid", 32'(evt.evt_valid), 32'd0);
        chk("ovf_drained_sb", 32'(sb.size()), 32'd0);
        // full queue accepting new events while popping
        evt.evt_ready = 1'b0;
        btn_in = 4'b1111;
        for (int i = 0; i < 4; i++) expect_evt(1'b1, 4'(i));
        to_edge(312);
        btn_in = 4'b0001;
        for (int i = 1; i < 4; i++) expect_evt(1'b0, 4'(i));
        to_edge(336);
        evt.evt_ready = 1'b1;
        to_edge(339);
        evt.evt_ready = 1'b0;
        to_edge(340);
        chk("pp_no_overflow", 32'(overflow), 32'd0);
        chk("pp_head", 32'({evt.evt_press, evt.evt_idx}), 32'h13);
        to_edge(344);
        evt.evt_ready = 1'b1;
        to_edge(350);
        chk("pp_drained_valid", 32'(evt.evt_valid), 32'd0);
        chk("pp_drained_sb", 32'(sb.size()), 32'd0);
        // reset with two events queued and button 2 mid-debounce
        evt.evt_ready = 1'b0;
        btn_in = 4'b1000;
        expect_evt(1'b0, 4'd0);
        expect_evt(1'b1, 4'd3);
        to_edge(378);
        btn_in = 4'b1100;
        to_edge(385);
        chk("pre_reset_valid", 32'(evt.evt_valid), 32'd1);
        chk("pre_reset_state", 32'(btn_state), 32'h8);
        rst = 1'b1;
        btn_in = 4'b1000;
        sb.delete();
        to_edge(386);
        chk_all_zero("midreset");
        rst = 1'b0;
        e = 0;
        evt.evt_ready = 1'b1;
        expect_evt(1'b1, 4'd3);
        to_edge(23); chk("held_before", 32'(btn_state), 32'h0);
        to_edge(24); chk("held_at", 32'(btn_state), 32'h8);
        to_edge(40);
        chk("final_valid", 32'(evt.evt_valid), 32'd0);
        chk("final_sb", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
